oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
CPU-bus initiator that performs sprite-RAM DMA. It snoops CPU writes to 0x4014 and latches the written byte as a source page. It then halts the CPU and takes the CPU-side bus into mem_decode. It copies 256 bytes from {page,00..FF} into 0x2004 (OAMDATA) as 256 read/write pairs, then hands the bus back to the CPU.

Parameters:
READ_LATENCY, 1, cycles after a dma_read_en cycle until dma_data_in is valid (>=1)
ALIGN_ODD, 1, 1 = insert one dummy cycle when the transfer starts on an odd cycle (NES 513/514 behaviour)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cpu_addr  in  16  CPU-issued address (snooped)
cpu_data_in  in  8  CPU write data (snooped)
cpu_write_en  in  1  CPU write strobe (snooped)
cpu_rdy  out  1  1 = CPU may execute; 0 = CPU stalled
bus_sel  out  1  1 = DMA drives the mem_decode CPU port (external mux select)
dma_addr  out  16  DMA bus address
dma_data_out  out  8  DMA write data
dma_write_en  out  1  DMA write strobe
dma_read_en  out  1  DMA read strobe
dma_data_in  in  8  read data returned from the mem_decode cpu_data_out
dma_busy  out  1  transfer in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst.
- Reset values: state=IDLE, cpu_rdy=1, bus_sel=0, dma_busy=0, dma_addr=0, dma_data_out=0, dma_write_en=0, dma_read_en=0. Internal page=0, idx=0, data register=0, parity=0.
- parity: a free-running flop that toggles every clk. It is not cleared by a transfer.
- Trigger: in IDLE, when cpu_write_en=1 and cpu_addr==16'h4014, capture page<=cpu_data_in and idx<=0, then go to HALT. Triggers are ignored in every non-IDLE state.
- State machine:
  - IDLE: bus released, cpu_rdy=1.
  - HALT: exactly 1 cycle. cpu_rdy=0, bus_sel=0, which lets the CPU finish its in-flight access. Exit goes to ALIGN if ALIGN_ODD=1 and parity==1 in this cycle, otherwise to READ.
  - ALIGN: exactly 1 cycle. bus_sel=1, no strobes. Then READ.
  - READ: 1 cycle. dma_addr={page,idx}, dma_read_en=1. Then WAIT.
  - WAIT: READ_LATENCY cycles, no strobes, dma_addr held. On the clock edge ending the last WAIT cycle, data register<=dma_data_in. Then WRITE.
  - WRITE: 1 cycle. dma_addr=16'h2004, dma_data_out=data register, dma_write_en=1. If idx==8'hFF go to DONE; otherwise idx<=idx+1 and go to READ.
  - DONE: 1 cycle. bus_sel=0 and strobes low. Next cycle is IDLE, where cpu_rdy returns to 1.
- Output timing: all outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- cpu_rdy and dma_busy: cpu_rdy=0 and dma_busy=1 from HALT through DONE inclusive.
- bus_sel: bus_sel=1 from ALIGN/READ through WRITE.
- Strobes: dma_read_en and dma_write_en are never both high. Neither is ever high while bus_sel=0.
- Total stall: 1 + align + 256*(2+READ_LATENCY) + 1 cycles. With the defaults this is 770 (even start) or 771 (odd start).
- Address arithmetic: idx is 8 bits and wraps from FF to 00 without carrying into page. Page FF reads 0xFF00..0xFFFF. Page 0x20..0x3F reads register space with no special case; side effects belong to mem_decode.
- OAMADDR: never written. The copy starts at whatever spram address the CPU last set, and the mem_decode auto-increment handles sequencing and wraps at 256.
- Reset mid-transfer: the block returns immediately to reset values. The bus is released and cpu_rdy=1; the partial copy is not resumed.
- Simultaneous events: a CPU write to 0x4014 on the same cycle as DONE is ignored. The CPU is still stalled then and its bus is not connected.

Decomposition:
- Package nes_bus_pkg holds: OAM_DMA_REG=16'h4014, OAMDATA_REG=16'h2004, and the state enum (IDLE, HALT, ALIGN, READ, WAIT, WRITE, DONE). mem_decode register decode reuses the same constants.
- No sub-module: the FSM, the latency counter and the index counter sit in one block. The bus mux sits at the top level.

Test Plan:
- Even-parity trigger, page 0x02, RAM 0x0200+i = i^0x5A, OAMADDR=0: after completion spram[i]==i^0x5A for all 256 entries; cpu_rdy low for exactly 770 cycles; 256 dma_write_en pulses, all at 0x2004.
- Odd-parity trigger: one ALIGN cycle observed; stall is 771 cycles; data identical to the even case.
- Page 0xFF: last read address is 0xFFFF; dma_addr never shows 0x0000 or 0x10xx; 256 reads.
- OAMADDR preset to 0xF0: byte 0 lands in spram[0xF0] and byte 0x10 lands in spram[0x00], confirming the wrap.
- rst asserted during the WRITE of idx=0x40: outputs take reset values asynchronously; cpu_rdy=1; spram[0x00..0x3F] updated and spram[0x41..] unchanged. A new trigger then runs a full 256-byte copy.
- Second 0x4014 write issued during HALT or WAIT (forced on the snoop port): page unchanged, no restart, transfer length unchanged.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the OAM DMA state encoding.
// mem_decode uses the same register addresses for its own decode.
package nes_bus_pkg;

  // CPU write here starts a sprite DMA; the written byte is the source page
  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  // Sprite RAM data port; mem_decode auto-increments OAMADDR on each write
  localparam logic [15:0] OAMDATA_REG = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WAIT  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA initiator. Snoops CPU writes to 0x4014, stalls the CPU,
// copies 256 bytes from {page,00..FF} into OAMDATA as read/write pairs,
// then returns the bus. All outputs decode from registered state only.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ALIGN_ODD    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  output logic        cpu_rdy,
  output logic        bus_sel,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  output logic        dma_write_en,
  output logic        dma_read_en,
  input  logic [7:0]  dma_data_in,
  output logic        dma_busy
);

  // Latency counter only needs to reach READ_LATENCY-1
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(READ_LATENCY - 1);

  dma_state_e     state_q, state_d;
  logic [7:0]     page_q, page_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     data_q, data_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic           parity_q, parity_d;

  logic           trigger;

  assign trigger = cpu_write_en && (cpu_addr == OAM_DMA_REG);

  // Next-state, page/index/data capture and the free-running parity toggle
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    wcnt_d   = wcnt_q;
    parity_d = ~parity_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d  = cpu_data_in;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // Odd start costs one extra cycle to line up reads on even cycles
        if ((ALIGN_ODD != 0) && parity_q) begin
          state_d = ALIGN;
        end else begin
          state_d = READ;
        end
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == LAST_WAIT) begin
          data_d  = dma_data_in;
          state_d = WRITE;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        // idx wraps inside the page; the page byte is never carried into
        if (idx_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      DONE: begin
        // A 0x4014 write here is dropped: the CPU is still stalled
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and parity registers; reset abandons any partial copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      wcnt_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      wcnt_q   <= wcnt_d;
      parity_q <= parity_d;
    end
  end

  // Bus outputs decoded purely from registered state and datapath
  always_comb begin
    cpu_rdy      = (state_q == IDLE);
    dma_busy     = (state_q != IDLE);
    bus_sel      = 1'b0;
    dma_addr     = 16'h0000;
    dma_data_out = 8'h00;
    dma_read_en  = 1'b0;
    dma_write_en = 1'b0;
    case (state_q)
      ALIGN: begin
        bus_sel  = 1'b1;
        dma_addr = {page_q, idx_q};
      end
      READ: begin
        bus_sel     = 1'b1;
        dma_addr    = {page_q, idx_q};
        dma_read_en = 1'b1;
      end
      WAIT: begin
        bus_sel  = 1'b1;
        dma_addr = {page_q, idx_q};
      end
      WRITE: begin
        bus_sel      = 1'b1;
        dma_addr     = OAMDATA_REG;
        dma_data_out = data_q;
        dma_write_en = 1'b1;
      end
      default: begin
        bus_sel = 1'b0;
      end
    endcase
  end

  // Bus-safety invariants
  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst)
    !(dma_read_en && dma_write_en));
  a_strobe_owned : assert property (@(posedge clk) disable iff (!rst)
    (dma_read_en || dma_write_en) |-> bus_sel);
  a_stall_covers_bus : assert property (@(posedge clk) disable iff (!rst)
    bus_sel |-> !cpu_rdy);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a behavioural RAM answers reads, a
// behavioural sprite RAM with auto-incrementing OAMADDR absorbs writes.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic        cpu_rdy;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic        dma_write_en;
  logic        dma_read_en;
  logic [7:0]  dma_data_in = 8'h00;
  logic        dma_busy;

  oam_dma_ctrl #(.READ_LATENCY(1), .ALIGN_ODD(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_write_en(cpu_write_en),
    .cpu_rdy(cpu_rdy), .bus_sel(bus_sel),
    .dma_addr(dma_addr), .dma_data_out(dma_data_out),
    .dma_write_en(dma_write_en), .dma_read_en(dma_read_en),
    .dma_data_in(dma_data_in), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];

  int          stall_cnt, last_stall, rd_cnt, wr_cnt, bad_addr;
  logic        align_seen, prev_bus_sel;
  logic [15:0] last_rd;
  int          cyc;

  logic [7:0]  spram [256];
  logic [7:0]  oamaddr = 8'h00;
  logic        oam_set = 1'b0;
  logic [7:0]  oam_set_val = 8'h00;
  logic        fill_req = 1'b0;

  // RAM contents: page 0x02 gives i^0x5A
  function automatic logic [7:0] memval(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h58;
  endfunction

  // Cycle count since reset release; bit 0 tracks the DUT parity flop
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Memory with one cycle read latency
  always @(posedge clk) begin
    if (dma_read_en) dma_data_in <= memval(dma_addr);
  end

  // Sprite RAM with OAMADDR auto-increment (mem_decode behaviour)
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) spram[i] <= 8'hEE;
    end else if (oam_set) begin
      oamaddr <= oam_set_val;
    end else if (rst && dma_write_en && dma_addr == 16'h2004) begin
      spram[oamaddr] <= dma_data_out;
      oamaddr        <= oamaddr + 8'd1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt    = 0;
        prev_bus_sel = 1'b0;
        continue;
      end
      if (dma_read_en || dma_write_en) begin
        check("strobe_excl", int'(dma_read_en && dma_write_en), 0);
        check("strobe_bus_sel", int'(bus_sel), 1);
      end
      if (bus_sel && (dma_addr == 16'h0000 || dma_addr[15:8] == 8'h10)) bad_addr++;
      if (bus_sel && !prev_bus_sel && !dma_read_en && !dma_write_en) align_seen = 1'b1;
      prev_bus_sel = bus_sel;
      if (dma_read_en) begin
        rd_cnt++;
        last_rd = dma_addr;
        if (rd_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read", dma_addr);
        end else begin
          check("rd_addr", int'(dma_addr), int'(rd_q.pop_front()));
        end
      end
      if (dma_write_en) begin
        wr_cnt++;
        check("wr_addr", int'(dma_addr), 16'h2004);
        if (wr_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL wr_unexpected: got 0x%0h expected no write", dma_data_out);
        end else begin
          check("wr_data", int'(dma_data_out), int'(wr_q.pop_front()));
        end
      end
      if (!cpu_rdy) stall_cnt++;
      else if (stall_cnt != 0) begin
        last_stall = stall_cnt;
        stall_cnt  = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic set_oam(input logic [7:0] v);
    oam_set_val = v; oam_set = 1'b1; step(); oam_set = 1'b0;
  endtask

  task automatic push_expect(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({page, 8'(i)});
      wr_q.push_back(memval({page, 8'(i)}));
    end
    rd_cnt = 0; wr_cnt = 0; bad_addr = 0; align_seen = 1'b0; last_stall = 0;
  endtask

  // Issue the 0x4014 write so that the HALT cycle has the requested parity
  task automatic trigger(input logic [7:0] page, input bit odd);
    step();
    while (bit'((cyc + 1) & 1) != odd) step();
    cpu_addr = 16'h4014; cpu_data_in = page; cpu_write_en = 1'b1;
    step();
    cpu_write_en = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (dma_busy && t < 3000) begin step(); t++; end
    if (dma_busy) check("done_timeout", int'(dma_busy), 0);
    step();
  endtask

  task automatic check_spram(input logic [7:0] page, input logic [7:0] start);
    int mism;
    mism = 0;
    for (int i = 0; i < 256; i++)
      if (spram[8'(start + 8'(i))] !== memval({page, 8'(i)})) mism++;
    check("spram_contents", mism, 0);
  endtask

  task automatic post_checks(input logic [7:0] page, input bit odd, input logic [7:0] start);
    check("stall_len", last_stall, odd ? 771 : 770);
    check("align_seen", int'(align_seen), int'(odd));
    check("rd_count", rd_cnt, 256);
    check("wr_count", wr_cnt, 256);
    check("queues_drained", rd_q.size() + wr_q.size(), 0);
    check("last_rd_addr", int'(last_rd), int'({page, 8'hFF}));
    check_spram(page, start);
  endtask

  task automatic run_copy(input logic [7:0] page, input bit odd, input logic [7:0] start);
    set_oam(start);
    push_expect(page);
    trigger(page, odd);
    wait_done();
    post_checks(page, odd, start);
  endtask

  initial begin
    int t;
    bit poked;
    rst = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00; cpu_write_en = 1'b0;
    stall_cnt = 0; last_stall = 0; rd_cnt = 0; wr_cnt = 0; bad_addr = 0;
    align_seen = 1'b0; prev_bus_sel = 1'b0; last_rd = 16'h0000;
    fork monitor_loop(); join_none
    fill_req = 1'b1;
    #12;
    check("rst_cpu_rdy", int'(cpu_rdy), 1);
    check("rst_bus_sel", int'(bus_sel), 0);
    check("rst_busy", int'(dma_busy), 0);
    check("rst_addr", int'(dma_addr), 0);
    check("rst_dout", int'(dma_data_out), 0);
    check("rst_we", int'(dma_write_en), 0);
    check("rst_re", int'(dma_read_en), 0);
    step(); fill_req = 1'b0; step();
    rst = 1'b1;

    // Writes to neighbouring registers must not start a copy
    cpu_addr = 16'h4013; cpu_data_in = 8'h02; cpu_write_en = 1'b1; step();
    cpu_addr = 16'h4015; step();
    cpu_write_en = 1'b0; step();
    check("no_false_trigger", int'(dma_busy), 0);

    run_copy(8'h02, 1'b0, 8'h00);
    run_copy(8'h02, 1'b1, 8'h00);
    run_copy(8'hFF, 1'b0, 8'h00);
    check("pageff_no_bad_addr", bad_addr, 0);
    run_copy(8'h03, 1'b0, 8'hF0);
    check("oam_wrap_byte0", int'(spram[8'hF0]), int'(memval(16'h0300)));
    check("oam_wrap_byte10", int'(spram[8'h00]), int'(memval(16'h0310)));

    // Reset while the WRITE of idx 0x40 is on the bus
    fill_req = 1'b1; step(); fill_req = 1'b0;
    set_oam(8'h00);
    push_expect(8'h04);
    trigger(8'h04, 1'b0);
    t = 0;
    while (!(dma_write_en && wr_cnt == 65) && t < 1000) begin step(); t++; end
    check("abort_reached_idx40", wr_cnt, 65);
    rst = 1'b0;
    #1;
    check("abort_cpu_rdy", int'(cpu_rdy), 1);
    check("abort_bus_sel", int'(bus_sel), 0);
    check("abort_busy", int'(dma_busy), 0);
    check("abort_we", int'(dma_write_en), 0);
    check("abort_addr", int'(dma_addr), 0);
    rd_q.delete(); wr_q.delete();
    step(); step(); rst = 1'b1; step(); step();
    check("abort_spram00", int'(spram[8'h00]), int'(memval(16'h0400)));
    check("abort_spram3f", int'(spram[8'h3F]), int'(memval(16'h043F)));
    check("abort_spram40", int'(spram[8'h40]), 8'hEE);
    check("abort_spram41", int'(spram[8'h41]), 8'hEE);
    check("abort_no_restart", int'(dma_busy), 0);
    run_copy(8'h04, 1'b1, 8'h00);

    // Re-trigger attempts during HALT, READ/WAIT and DONE are all ignored
    set_oam(8'h00);
    push_expect(8'h05);
    trigger(8'h05, 1'b0);
    cpu_addr = 16'h4014; cpu_data_in = 8'h06; cpu_write_en = 1'b1;
    for (int k = 0; k < 6; k++) step();
    cpu_write_en = 1'b0;
    poked = 1'b0;
    t = 0;
    while (dma_busy && t < 3000) begin
      if (!poked && !bus_sel && wr_cnt == 256) begin
        cpu_addr = 16'h4014; cpu_data_in = 8'h07; cpu_write_en = 1'b1;
        poked = 1'b1;
      end
      step(); t++;
      cpu_write_en = 1'b0;
    end
    check("retrig_done_poked", int'(poked), 1);
    step();
    post_checks(8'h05, 1'b0, 8'h00);
    step(); step();
    check("retrig_no_restart", int'(dma_busy), 0);
    check("retrig_cpu_rdy", int'(cpu_rdy), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
